keypad_matrix_emulator: RTL

Synthesizable 3x3 keypad matrix model: the responding end of the column-scan / row-sense keypad interface. A test harness or on-board self-test driver issues press/release commands for key indices 0-8. The block answers the scanner's active-low column drive on active-low row lines and injects pseudo-random contact bounce on every transition. It replaces the physical keypad, so the keypad controller and game logic can run in simulation and in hardware loopback.

---
 rtl/keypad_matrix_emulator.sv | 104 ++++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// 3x3 keypad matrix model: answers an active-low column scan on active-low rows and
// injects LFSR-driven contact bounce on every commanded press or release.
module keypad_matrix_emulator #(
   parameter int unsigned BOUNCE_CYCLES = 16,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_press_valid,
   input  logic [3:0] i_press_key,
   input  logic       i_press_down,
   output logic       o_press_ready,
   input  logic [2:0] i_column,
   output logic [2:0] o_row,
   output logic [8:0] o_key_state,
   output logic       o_error
);

   typedef enum logic {
      StIdle,
      StBounce
   } state_t;

   localparam logic [7:0] CntLoad = 8'(BOUNCE_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_count;
   logic [3:0] r_target;
   logic       r_level;
   logic [8:0] r_contact;
   logic [8:0] r_key_state;
   logic [7:0] r_lfsr;
   logic [2:0] r_row;
   logic       r_ready;
   logic       r_error;

   logic       w_lfsr_fb;
   logic [2:0] w_row_next;

   // Taps for x^8+x^6+x^5+x^4+1
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   // Any pressed key on a driven (low) column pulls its row low; ghosting is intentional.
   always_comb begin
      w_row_next = 3'b111;
      for (int r = 0; r < 3; r++) begin
         w_row_next[r] = ~|(r_contact[3*r +: 3] & ~i_column);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_count     <= 8'd0;
         r_target    <= 4'd0;
         r_level     <= 1'b0;
         r_contact   <= 9'd0;
         r_key_state <= 9'd0;
         r_lfsr      <= LFSR_SEED;
         r_row       <= 3'b111;
         r_ready     <= 1'b1;
         r_error     <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
         r_row  <= w_row_next;
         unique case (r_state)
            StIdle: begin
               if (i_press_valid) begin
                  if (i_press_key > 4'd8) begin
                     r_error <= 1'b1;
                  end else if (i_press_down != r_key_state[i_press_key]) begin
                     r_target <= i_press_key;
                     r_level  <= i_press_down;
                     r_count  <= CntLoad;
                     r_ready  <= 1'b0;
                     r_state  <= StBounce;
                  end
               end
            end
            StBounce: begin
               if (r_count == 8'd0) begin
                  r_contact[r_target]   <= r_level;
                  r_key_state[r_target] <= r_level;
                  r_ready               <= 1'b1;
                  r_state               <= StIdle;
               end else begin
                  r_contact[r_target] <= r_lfsr[0];
                  r_count             <= r_count - 8'd1;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_press_ready = r_ready;
   assign o_row         = r_row;
   assign o_key_state   = r_key_state;
   assign o_error       = r_error;

endmodule
